// File: rtl/id_pkg.sv
// Shared types and constants for the id_fsm character feeder.
package id_pkg;

    localparam int WORD_W         = 32;
    localparam int CHARS_PER_WORD = 4;
    localparam int LEN_W          = 3;
    localparam logic [7:0] CHAR_NUL = 8'h00;

    typedef enum logic {
        IDLE,
        SHIFT
    } ser_state_t;

    typedef logic [1:0] idx_t;

    // Byte 0 is the MSB end of the word.
    function automatic logic [7:0] get_char(input logic [WORD_W-1:0] w, input idx_t i);
        logic [7:0] c;
        case (i)
            2'd0:    c = w[31:24];
            2'd1:    c = w[23:16];
            2'd2:    c = w[15:8];
            default: c = w[7:0];
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_char_feeder_if.sv
// Word input handshake plus character output bundle of the feeder.
interface id_char_feeder_if;
    import id_pkg::*;

    logic [WORD_W-1:0] in_word;
    logic [LEN_W-1:0]  in_len;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [7:0]        char;
    logic              char_valid;
    logic              busy;

    modport master (
        output in_word, in_len, in_valid, flush,
        input  in_ready, char, char_valid, busy
    );

    modport slave (
        input  in_word, in_len, in_valid, flush,
        output in_ready, char, char_valid, busy
    );

endinterface

// File: rtl/id_word_fifo.sv
// Small word FIFO holding a packed word and its effective length.
module id_word_fifo
    import id_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [WORD_W-1:0] push_word,
    input  logic [LEN_W-1:0]  push_len,
    output logic              full,
    output logic              empty,
    output logic [WORD_W-1:0] head_word,
    output logic [LEN_W-1:0]  head_len
);

    localparam int AW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem_word [DEPTH];
    logic [LEN_W-1:0]  mem_len  [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full && !flush;
    assign do_pop    = pop && !empty && !flush;
    assign head_word = mem_word[rd_ptr];
    assign head_len  = mem_len[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_word[wr_ptr] <= push_word;
            mem_len[wr_ptr]  <= push_len;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/id_char_feeder.sv
// Buffers packed ASCII words and serializes them onto a registered char stream.
module id_char_feeder
    import id_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    id_char_feeder_if.slave  bus
);

    ser_state_t        state;
    logic [WORD_W-1:0] word_r;
    idx_t              idx;
    idx_t              last;
    logic [7:0]        char_r;
    logic              char_valid_r;

    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W-1:0] head_word;
    logic [LEN_W-1:0]  head_len;
    logic [LEN_W-1:0]  eff_len;
    logic              at_last;
    logic              can_load;
    logic              pop;

    assign eff_len  = (bus.in_len > 3'd4) ? 3'd4 : bus.in_len;
    assign at_last  = (state == SHIFT) && (idx == last);
    // The last byte cycle can already fetch the next word, so streams have no gaps.
    assign can_load = (state == IDLE) || at_last;
    assign pop      = can_load && !fifo_empty && !bus.flush;

    id_word_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (bus.in_valid),
        .pop       (pop),
        .flush     (bus.flush),
        .push_word (bus.in_word),
        .push_len  (eff_len),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_word (head_word),
        .head_len  (head_len)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            word_r       <= '0;
            idx          <= '0;
            last         <= '0;
            char_r       <= CHAR_NUL;
            char_valid_r <= 1'b0;
        end else if (bus.flush) begin
            state        <= IDLE;
            idx          <= '0;
            char_r       <= CHAR_NUL;
            char_valid_r <= 1'b0;
        end else if ((state == SHIFT) && !at_last) begin
            idx          <= idx_t'(idx + 2'd1);
            char_r       <= get_char(word_r, idx_t'(idx + 2'd1));
            char_valid_r <= 1'b1;
        end else if (!fifo_empty) begin
            if (head_len == '0) begin
                // Zero-length word: consumed, costs one NUL cycle.
                state        <= IDLE;
                char_r       <= CHAR_NUL;
                char_valid_r <= 1'b0;
            end else begin
                word_r       <= head_word;
                idx          <= '0;
                last         <= idx_t'(head_len - 3'd1);
                char_r       <= get_char(head_word, 2'd0);
                char_valid_r <= 1'b1;
                state        <= (head_len > 3'd1) ? SHIFT : IDLE;
            end
        end else begin
            state        <= IDLE;
            char_r       <= CHAR_NUL;
            char_valid_r <= 1'b0;
        end
    end

    assign bus.char       = char_r;
    assign bus.char_valid = char_valid_r;
    assign bus.in_ready   = !fifo_full;
    assign bus.busy       = !fifo_empty || (state == SHIFT);

endmodule

// File: tb/tb_id_char_feeder.sv
// Directed bench for id_char_feeder: vector table plus multi-cycle sequences.
module tb_id_char_feeder;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   failed = 0;

    id_char_feeder_if bus ();

    id_char_feeder #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     word;
        logic [2:0]      len;
        int              n;
        logic [3:0][7:0] exp;   // exp[3] is the first char
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.in_word  = '0;
        bus.in_len   = '0;
    endtask

    logic [7:0] got [$];

    initial begin
        vecs[0] = '{32'h61763931, 3'd4, 4, {8'h61, 8'h76, 8'h39, 8'h31}};
        vecs[1] = '{32'h61620000, 3'd2, 2, {8'h61, 8'h62, 8'h00, 8'h00}};
        vecs[2] = '{32'h41424344, 3'd0, 0, {8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[3] = '{32'h5758595A, 3'd7, 4, {8'h57, 8'h58, 8'h59, 8'h5A}};
        vecs[4] = '{32'h7A000000, 3'd1, 1, {8'h7A, 8'h00, 8'h00, 8'h00}};
        vecs[5] = '{32'h41424344, 3'd3, 3, {8'h41, 8'h42, 8'h43, 8'h00}};

        idle_inputs();
        rst_n = 1'b0;
        #12;
        chk("rst_char", bus.char, 8'h00);
        chk("rst_valid", bus.char_valid, 0);
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        tick();
        tick();

        // Single words into an empty FIFO
        foreach (vecs[v]) begin
            bus.in_word  = vecs[v].word;
            bus.in_len   = vecs[v].len;
            bus.in_valid = 1'b1;
            tick();
            idle_inputs();
            chk($sformatf("vec%0d_pre", v), bus.char_valid, 0);
            tick();
            for (int i = 0; i < vecs[v].n; i++) begin
                chk($sformatf("vec%0d_char%0d", v, i), bus.char, vecs[v].exp[3-i]);
                chk($sformatf("vec%0d_vld%0d", v, i), bus.char_valid, 1);
                tick();
            end
            chk($sformatf("vec%0d_nul", v), bus.char, 8'h00);
            chk($sformatf("vec%0d_nulvld", v), bus.char_valid, 0);
            chk($sformatf("vec%0d_busy", v), bus.busy, 0);
            tick();
        end

        // Back-to-back words stream without a NUL gap
        begin
            logic [7:0] bb [8];
            bb = '{8'h61, 8'h76, 8'h39, 8'h31, 8'h2F, 8'h61, 8'h61, 8'h61};
            bus.in_word = 32'h61763931; bus.in_len = 3'd4; bus.in_valid = 1'b1;
            tick();
            bus.in_word = 32'h2F616161;
            tick();
            idle_inputs();
            for (int j = 0; j < 8; j++) begin
                chk($sformatf("b2b_char%0d", j), bus.char, bb[j]);
                chk($sformatf("b2b_vld%0d", j), bus.char_valid, 1);
                if (j < 7) tick();
            end
            chk("b2b_busy_last", bus.busy, 1);
            tick();
            chk("b2b_nul", bus.char, 8'h00);
            chk("b2b_nulvld", bus.char_valid, 0);
            chk("b2b_busy_end", bus.busy, 0);
            tick();
        end

        // Full FIFO back-pressure: six words, fifth queued one held off a cycle
        begin
            logic [31:0] fw [6];
            fw = '{32'h41424344, 32'h45464748, 32'h494A4B4C,
                   32'h4D4E4F50, 32'h51525354, 32'h55565758};
            got.delete();
            fork
                begin
                    for (int i = 0; i < 6; i++) begin
                        int w;
                        bus.in_word = fw[i]; bus.in_len = 3'd4; bus.in_valid = 1'b1;
                        w = 0;
                        while (!bus.in_ready && w < 10) begin
                            tick();
                            w++;
                        end
                        if (i == 5) chk("full_holdoff_cycles", w, 1);
                        tick();
                        if (i == 4) chk("full_ready_low", bus.in_ready, 0);
                    end
                    idle_inputs();
                end
                begin
                    repeat (40) begin
                        @(posedge clk);
                        #1;
                        if (bus.char_valid) got.push_back(bus.char);
                    end
                end
            join
            chk("full_char_count", got.size(), 24);
            for (int j = 0; j < 24 && j < got.size(); j++)
                chk($sformatf("full_char%0d", j), got[j], 8'h41 + j);
            chk("full_busy_end", bus.busy, 0);
        end

        // Flush mid-word with three words queued; same-cycle push dropped
        bus.in_len = 3'd4; bus.in_valid = 1'b1;
        bus.in_word = 32'h41424344; tick();
        bus.in_word = 32'h45464748; tick();
        bus.in_word = 32'h494A4B4C; tick();
        bus.in_word = 32'h4D4E4F50; tick();
        chk("pre_flush_busy", bus.busy, 1);
        chk("pre_flush_char", bus.char, 8'h43);
        bus.in_word = 32'h51525354; bus.flush = 1'b1;
        tick();
        idle_inputs();
        chk("flush_char", bus.char, 8'h00);
        chk("flush_vld", bus.char_valid, 0);
        chk("flush_busy", bus.busy, 0);
        chk("flush_ready", bus.in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("post_flush_vld%0d", i), bus.char_valid, 0);
        end

        // Asynchronous reset mid-word
        bus.in_word = 32'h61763931; bus.in_len = 3'd4; bus.in_valid = 1'b1;
        tick();
        idle_inputs();
        tick();
        tick();
        chk("pre_rst_char", bus.char, 8'h76);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_char", bus.char, 8'h00);
        chk("arst_vld", bus.char_valid, 0);
        chk("arst_ready", bus.in_ready, 1);
        chk("arst_busy", bus.busy, 0);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("post_rst_vld%0d", i), bus.char_valid, 0);
            chk($sformatf("post_rst_busy%0d", i), bus.busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
